// File: rtl/hl2link_pkg.sv
// Shared definitions for the HL2 board-to-board link framer.
package hl2link_pkg;

  localparam logic [1:0] SYM_IDLE  = 2'b00;
  localparam logic [1:0] SYM_START = 2'b11;

  localparam int FRAME_DATA_SYMS = 19;
  localparam int FRAME_W         = 2 * FRAME_DATA_SYMS;

  localparam logic [1:0] TUSER_CMD    = 2'b01;
  localparam logic [1:0] TUSER_STREAM = 2'b10;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_TYPE,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } rx_state_e;

  // Only command and stream frames are deliverable; 00 and 11 are reserved.
  function automatic logic type_ok(input logic [1:0] t);
    return (t == TUSER_CMD) || (t == TUSER_STREAM);
  endfunction

endpackage

// File: rtl/hl2link_rx_shift.sv
// Two-lane deserializer for the frame DATA field: shifts one symbol per
// cycle, keeps per-lane running parity (seeded with the TYPE symbol) and
// counts DATA symbols. done flags the shift that completes the field.
module hl2link_rx_shift
  import hl2link_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [1:0]         sym,
  output logic [FRAME_W-1:0] data,
  output logic [1:0]         par,
  output logic               done
);

  logic [4:0] cnt;

  // DATA symbol counter, restarted by every TYPE symbol
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (load)  cnt <= '0;
    else if (shift) cnt <= cnt + 5'd1;
  end

  // Payload shift and lane parity; pure datapath, always reloaded before use
  always_ff @(posedge clk) begin
    if (load) begin
      par <= sym;
    end else if (shift) begin
      data <= {data[FRAME_W-3:0], sym};
      par  <= par ^ sym;
    end
  end

  assign done = shift && (cnt == 5'(FRAME_DATA_SYMS - 1));

endmodule

// File: rtl/hl2link_rx.sv
// Receive framer for the two-lane HL2 link: acquires sync on an idle run,
// deserializes parity-protected 23-symbol frames and holds each good frame
// on the recv_* stream until accepted.
// Optional feature: define HL2LINK_RX_ERRCNT_EN to add a saturating
// err_count[7:0] output counting recv_error pulses.
module hl2link_rx
  import hl2link_pkg::*;
#(
  parameter int IDLE_MIN = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         linkrx,
  input  logic               rx_clear,
  output logic               recv_tvalid,
  output logic [FRAME_W-1:0] recv_tdata,
  output logic [1:0]         recv_tuser,
  input  logic               recv_tready,
  output logic               recv_tdone,
  output logic               recv_error,
  output logic               synced
`ifdef HL2LINK_RX_ERRCNT_EN
  ,
  output logic [7:0]         err_count
`endif
);

  rx_state_e          state, state_nxt;
  logic [1:0]         sym;
  logic [7:0]         idle_cnt;
  logic [1:0]         type_q;
  logic               par_ok;
  logic               ld, sh, done;
  logic [FRAME_W-1:0] sh_data;
  logic [1:0]         sh_par;
  logic               commit, err_ev, sync_set, sync_clr;
  logic               cnt_inc, cnt_clr, par_chk;

  // Register the lanes once before any decision is made on them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sym <= SYM_IDLE;
    else        sym <= linkrx;
  end

  hl2link_rx_shift u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ld),
    .shift (sh),
    .sym   (sym),
    .data  (sh_data),
    .par   (sh_par),
    .done  (done)
  );

  assign recv_tdone = recv_tvalid & recv_tready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= state_nxt;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    sh        = 1'b0;
    commit    = 1'b0;
    err_ev    = 1'b0;
    sync_set  = 1'b0;
    sync_clr  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    par_chk   = 1'b0;
    if (rx_clear) begin
      state_nxt = ST_SYNC;
      sync_clr  = 1'b1;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        ST_SYNC: begin
          if (sym == SYM_IDLE) begin
            // This idle is the IDLE_MIN-th of the run
            if (idle_cnt == 8'(IDLE_MIN - 1)) begin
              state_nxt = ST_IDLE;
              sync_set  = 1'b1;
              cnt_clr   = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end else begin
            cnt_clr = 1'b1;
          end
        end
        ST_IDLE: begin
          if (sym == SYM_START) begin
            state_nxt = ST_TYPE;
          end else if (sym != SYM_IDLE) begin
            state_nxt = ST_SYNC;
            sync_clr  = 1'b1;
            cnt_clr   = 1'b1;
            err_ev    = 1'b1;
          end
        end
        ST_TYPE: begin
          ld        = 1'b1;
          state_nxt = ST_DATA;
        end
        ST_DATA: begin
          sh = 1'b1;
          if (done) state_nxt = ST_PAR;
        end
        ST_PAR: begin
          par_chk   = 1'b1;
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if ((sym == SYM_IDLE) && par_ok && type_ok(type_q)) begin
            commit    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            err_ev    = 1'b1;
            state_nxt = ST_SYNC;
            sync_clr  = 1'b1;
            cnt_clr   = 1'b1;
          end
        end
        default: state_nxt = ST_SYNC;
      endcase
    end
  end

  // Idle-run counter, sync flag, frame type and parity verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      synced   <= 1'b0;
      type_q   <= '0;
      par_ok   <= 1'b0;
    end else begin
      if (cnt_clr)      idle_cnt <= '0;
      else if (cnt_inc) idle_cnt <= idle_cnt + 8'd1;
      if (sync_clr)      synced <= 1'b0;
      else if (sync_set) synced <= 1'b1;
      if (ld)      type_q <= sym;
      if (par_chk) par_ok <= (sym == sh_par);
    end
  end

  // Output holding: load on commit, release on accept, flag drops/overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recv_tvalid <= 1'b0;
      recv_tdata  <= '0;
      recv_tuser  <= '0;
      recv_error  <= 1'b0;
    end else begin
      recv_error <= err_ev | (commit & recv_tvalid & ~recv_tready);
      if (rx_clear)        recv_tvalid <= 1'b0;
      else if (commit)     recv_tvalid <= 1'b1;
      else if (recv_tdone) recv_tvalid <= 1'b0;
      if (commit) begin
        recv_tdata <= sh_data;
        recv_tuser <= type_q;
      end
    end
  end

`ifdef HL2LINK_RX_ERRCNT_EN
  // Saturating count of error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               err_count <= '0;
    else if (rx_clear)                        err_count <= '0;
    else if (recv_error && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule
